// File: rtl/sync111_tx.sv
// sync111_tx: serial framer, "111" sync, separator, stuffed LSB-first byte,
// odd parity bit and MIN_GAP trailing zeros on a registered line w.
// Ports: clk, arst (async, active-high), din/din_valid/din_ready (byte
// input, accepted only in IDLE), w (serial line), busy, frame_done (pulse).
module sync111_tx #(
  parameter int unsigned MIN_GAP = 1
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       w,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    IDLE, SYNC, SEP, DATA, PAR, GAP
  } state_t;

  localparam logic [3:0] GAP_LEN = 4'(MIN_GAP);

  state_t     state, state_n;
  logic [7:0] byte_q;
  logic [3:0] cnt, cnt_n;
  logic [1:0] ones, ones_n;
  logic       w_n, busy_n, done_n;
  logic       load;
  logic       stuff;
  logic       par_bit;

  // Two ones already on the line: the next cycle must be a stuffed 0.
  assign stuff   = (ones == 2'd2);
  assign par_bit = ~^byte_q;

  assign din_ready = (state == IDLE);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= IDLE;
      cnt        <= '0;
      ones       <= '0;
      byte_q     <= '0;
      w          <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ones       <= ones_n;
      w          <= w_n;
      busy       <= busy_n;
      frame_done <= done_n;
      if (load) byte_q <= din;
    end
  end

  // cnt: SYNC index, data bits consumed (DATA/PAR, 9 = parity sent),
  // or gap cycles done.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (din_valid) begin
          load    = 1'b1;
          state_n = SYNC;
          cnt_n   = '0;
        end
      end
      SYNC: begin
        if (cnt == 4'd2) begin
          state_n = SEP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      SEP: begin
        state_n = DATA;
        cnt_n   = 4'd1;
      end
      DATA: begin
        if (cnt == 4'd8) begin
          state_n = PAR;
          cnt_n   = stuff ? 4'd8 : 4'd9;
        end else if (!stuff) begin
          cnt_n = cnt + 4'd1;
        end
      end
      PAR: begin
        if (cnt == 4'd8) begin
          cnt_n = 4'd9;
        end else begin
          state_n = GAP;
          cnt_n   = 4'd1;
        end
      end
      GAP: begin
        if (cnt == GAP_LEN) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Value of the line and ones counter for the cycle being entered.
  always_comb begin
    w_n    = 1'b0;
    ones_n = '0;
    busy_n = (state_n != IDLE);
    done_n = (state == GAP) && (state_n == IDLE);
    unique case (state)
      IDLE: w_n = din_valid;
      SYNC: w_n = (cnt != 4'd2);
      SEP: begin
        w_n    = byte_q[0];
        ones_n = {1'b0, byte_q[0]};
      end
      DATA: begin
        if (stuff) begin
          w_n = 1'b0;
        end else if (cnt == 4'd8) begin
          w_n    = par_bit;
          ones_n = {1'b0, par_bit};
        end else begin
          w_n    = byte_q[cnt[2:0]];
          ones_n = w_n ? ones + 2'd1 : 2'd0;
        end
      end
      PAR: begin
        if (cnt == 4'd8) begin
          w_n    = par_bit;
          ones_n = {1'b0, par_bit};
        end
      end
      GAP: w_n = 1'b0;
      default: w_n = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sync111_tx.sv
// tb_sync111_tx: scoreboard bench for sync111_tx; stimulus pushes the
// expected frame, a negedge monitor captures and decodes each frame.
module tb_sync111_tx;

  localparam int G = 2;

  logic       clk = 1'b0;
  logic       arst;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       w;
  logic       busy;
  logic       frame_done;

  always #5 clk = ~clk;

  sync111_tx #(.MIN_GAP(G)) dut (
    .clk(clk),
    .arst(arst),
    .din(din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .w(w),
    .busy(busy),
    .frame_done(frame_done)
  );

  typedef struct {
    logic [7:0]  b;
    bit          has_raw;
    logic [63:0] raw;
    int          len;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(logic [7:0] b, string s);
    exp_t e;
    e.b       = b;
    e.has_raw = (s.len() > 0);
    e.raw     = '0;
    for (int i = 0; i < s.len(); i++)
      e.raw[i] = (s[i] == "1");
    e.len = s.len() + G;
    return e;
  endfunction

  task automatic frame_chk(exp_t e, logic [63:0] r, int n);
    logic [8:0] pl = '0;
    int i = 4;
    int k = 0;
    int ones = 0;
    bit stuff_ok = 1'b1;
    bit gap_ok = 1'b1;
    bit nos = 1'b1;
    if (e.has_raw) begin
      check("len", 64'(n), 64'(e.len));
      check("raw", r, e.raw);
    end
    check("sync", 64'(r[3:0]), 64'h7);
    while (k < 9 && i < n) begin
      if (ones == 2) begin
        if (r[i]) stuff_ok = 1'b0;
        ones = 0;
      end else begin
        pl[k] = r[i];
        k++;
        ones = r[i] ? ones + 1 : 0;
      end
      i++;
    end
    check("payload_len", 64'(k), 64'd9);
    check("gap_len", 64'(n - i), 64'(G));
    for (int j = i; j < n; j++)
      if (r[j]) gap_ok = 1'b0;
    check("gap_zero", 64'(gap_ok), 64'd1);
    check("stuff", 64'(stuff_ok), 64'd1);
    check("byte", 64'(pl[7:0]), 64'(e.b));
    check("parity", 64'(^pl), 64'd1);
    for (int j = 1; j + 2 < n; j++)
      if (r[j] && r[j+1] && r[j+2]) nos = 1'b0;
    check("false_sync", 64'(nos), 64'd1);
  endtask

  logic [63:0] cap = '0;
  int          clen = 0;
  logic        pb = 1'b0;

  always @(negedge clk) begin
    if (arst !== 1'b0) begin
      cap  = '0;
      clen = 0;
      pb   = 1'b0;
    end else begin
      check("frame_done", 64'(frame_done), 64'(pb && !busy));
      if (busy) begin
        if (clen < 64) cap[clen] = w;
        clen++;
      end else begin
        check("idle_w", 64'(w), 64'd0);
      end
      if (pb && !busy) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got len %0d want none", clen);
        end else begin
          frame_chk(q.pop_front(), cap, clen);
        end
        cap  = '0;
        clen = 0;
      end
      pb = busy;
    end
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!din_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got 0 want 1");
    end
  endtask

  task automatic send(logic [7:0] b, string s);
    wait_ready();
    din       = b;
    din_valid = 1'b1;
    q.push_back(mk(b, s));
    @(posedge clk);
    #1 din_valid = 1'b0;
  endtask

  initial begin
    int t;
    arst = 1'b1;
    #12;
    check("rst_w", 64'(w), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    check("rst_ready", 64'(din_ready), 64'd1);
    @(posedge clk);
    #2 arst = 1'b0;

    send(8'h00, "1110000000001");
    send(8'hFF, "11101101101101101");
    send(8'h03, "11101100000001");
    send(8'h01, "1110100000000");

    // din_valid while busy must not queue a second frame
    send(8'h3C, "111000110110001");
    din       = 8'h77;
    din_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1 din_valid = 1'b0;

    // back-to-back with din changing mid-frame
    wait_ready();
    din       = 8'hA5;
    din_valid = 1'b1;
    q.push_back(mk(8'hA5, "1110101001011"));
    q.push_back(mk(8'h5A, "11100101100101"));
    @(posedge clk);
    #1 din = 8'h5A;
    t = 0;
    @(negedge clk);
    while (!frame_done && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("b2b_done_seen", 64'(frame_done), 64'd1);
    check("b2b_ready", 64'(din_ready), 64'd1);
    @(posedge clk);
    #1 din = 8'h00;
    din_valid = 1'b0;
    @(negedge clk);
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_w", 64'(w), 64'd1);

    // async reset during data bit 4
    send(8'h00, "");
    repeat (8) @(posedge clk);
    #3;
    check("pre_rst_busy", 64'(busy), 64'd1);
    arst = 1'b1;
    #1;
    check("arst_w", 64'(w), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(frame_done), 64'd0);
    check("arst_ready", 64'(din_ready), 64'd1);
    void'(q.pop_back());
    din       = 8'h81;
    din_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2 arst = 1'b0;
    #1;
    check("rst_noaccept", 64'(busy), 64'd0);
    q.push_back(mk(8'h81, "1110100000011"));
    @(posedge clk);
    #1 din_valid = 1'b0;

    for (int n = 0; n < 1500; n++)
      send(8'($urandom_range(0, 255)), "");

    t = 0;
    while (q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("drain", 64'(q.size()), 64'd0);
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
